ydemux1to8_buf: RTL and testbench
=================================

# ydemux1to8_buf

Registered 1-to-8 demultiplexer with per-channel holding buffers: the reverse of the 8-to-1 selection path. A single SIZE-bit producer stream, tagged with a 3-bit destination select, is steered into one of eight single-entry output slots. Each slot is drained independently by its consumer through a valid/ready handshake. It sits between a shared datapath result bus and eight per-destination consumers.

## Interface
- SIZE, default 32: data width of the input word and of every output channel.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  SIZE  word to route.
- in_sel  input  3  destination channel 0..7; don't-care when in_valid=0.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word is accepted this cycle if in_valid=1.
- out_data0..out_data7  output  SIZE each  slot contents.
- out_valid  output  8  bit k = slot k holds a word.
- out_ready  input  8  bit k = consumer k takes slot k this cycle.
- accept_cnt  output  8  count of accepted input words, wraps at 256.

## Operation
- Accept condition: acc = in_valid & in_ready.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel]. It is combinational, and it depends on in_sel and out_ready but never on in_valid.
- Drain condition for slot k: drn[k] = out_valid[k] & out_ready[k]. The slot empties unless it is refilled in the same cycle.
- Slot k update at each edge:
  - If acc and in_sel==k: out_data_k <= in_data and out_valid[k] <= 1. This holds whether the slot was empty or draining.
  - Else if drn[k]: out_valid[k] <= 0, and out_data_k holds its last value.
  - Else: the slot holds.
- Slots other than in_sel are never modified by an accept.
- A full slot with out_ready[k]=0 backpressures only words addressed to k. Words for other channels keep flowing.
- out_ready[k] while out_valid[k]=0 has no effect.
- accept_cnt increments by 1 on every acc and wraps from 255 to 0.
- Order is preserved per channel. There is no ordering guarantee across channels.
- out_data_k must not change while out_valid[k]=1 and out_ready[k]=0.

## Timing
- Reset values, forced asynchronously when rst_n is low: out_valid=8'h00, every out_data_k={SIZE{1'b0}}, accept_cnt=0.
- Combinational output under reset: in_ready=1 (all slots empty).
- Reset asserted mid-transfer drops all buffered words. The first edge after rst_n rises behaves as from empty.
- Latency: a word accepted at edge N is visible on out_data_k with out_valid[k]=1 after edge N, i.e. one cycle.
- Throughput: one word per cycle.
- A single channel sustains full rate when its consumer holds out_ready[k]=1, because drain and refill happen at the same edge.
- No combinational path from in_data or in_valid to any output. The only combinational path is in_sel/out_ready to in_ready.

## Structure
- Shared package/include:
  - NCH=8 channel count.
  - SELW=3 select width.
  - CNTW=8 counter width.
  - Reset constants for the slot state.
- Sub-module ydemux_slot:
  - Contents: one holding register, its valid flag, and the fill/drain logic.
  - Ports: clk, rst_n, load, wdata, rdy, rdata, vld.
  - Instantiated 8 times.
- Top level contains:
  - the in_sel decoder (load = acc & (in_sel==k));
  - the in_ready mux;
  - accept_cnt.

## Test plan
- Reset then idle: after rst_n is released, check out_valid=00, accept_cnt=0, in_ready=1, and all out_data=0. Pulse rst_n low mid-run with slots 2 and 5 full, and require out_valid=00 immediately, without waiting for a clock edge.
- Single route: with in_sel=5, in_data=32'h0000_1234, in_valid=1 for one cycle and out_ready=0, require out_valid=8'b0010_0000 and out_data5=1234 on the next cycle, other slots unchanged, and accept_cnt=1.
- Backpressure isolation: with slot 3 full and out_ready[3]=0:
  - offering in_sel=3 must give in_ready=0, and the word is not taken;
  - switching to in_sel=6 must give in_ready=1, and the word is accepted into slot 6;
  - out_data3 stays stable throughout.
- Simultaneous drain and refill: with slot 0 holding 32'hA and out_ready[0]=1, present in_sel=0, data 32'hB in the same cycle. Require in_ready=1, out_valid[0] to stay 1, and out_data0=B next cycle. Over 10 back-to-back words, require 10 accepts in 10 cycles.
- Random sweep: send 1000 words with random in_sel, in_valid and out_ready. Per channel, the scoreboard compares FIFO order against a reference. Require no loss or duplication, and accept_cnt equal to accepted count mod 256, including at least one 255 to 0 wrap.
- Drain without refill: slot 7 full, out_ready=8'h80, in_valid=0. Require out_valid[7]=0 next cycle, and out_data7 to retain its value.

Source files
------------

// File: rtl/ydemux1to8_buf_pkg.sv
// Shared constants for the 1-to-8 buffered demux: channel geometry, counter
// width and slot reset values.
package ydemux1to8_buf_pkg;
  localparam int NCH  = 8;
  localparam int SELW = 3;
  localparam int CNTW = 8;

  localparam logic SLOT_VLD_RST      = 1'b0;
  localparam logic SLOT_DATA_RST_BIT = 1'b0;

  function automatic logic [NCH-1:0] sel_decode(input logic [SELW-1:0] sel);
    logic [NCH-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction
endpackage

// File: rtl/ydemux_slot.sv
// Single-entry holding slot: a load refills it (even while draining), and a
// drain without a load empties it but keeps the last data word.
module ydemux_slot
  import ydemux1to8_buf_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SIZE-1:0] wdata,
  input  logic            rdy,
  output logic [SIZE-1:0] rdata,
  output logic            vld
);
  logic [SIZE-1:0] data_q, data_d;
  logic            vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load) begin
      data_d = wdata;
      vld_d  = 1'b1;
    end else if (vld_q && rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= {SIZE{SLOT_DATA_RST_BIT}};
      vld_q  <= SLOT_VLD_RST;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign rdata = data_q;
  assign vld   = vld_q;
endmodule

// File: rtl/ydemux1to8_buf.sv
// Registered 1-to-8 demux: steers one tagged input word per cycle into one of
// eight independently drained single-entry slots.
module ydemux1to8_buf
  import ydemux1to8_buf_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] in_data,
  input  logic [SELW-1:0] in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] out_data0,
  output logic [SIZE-1:0] out_data1,
  output logic [SIZE-1:0] out_data2,
  output logic [SIZE-1:0] out_data3,
  output logic [SIZE-1:0] out_data4,
  output logic [SIZE-1:0] out_data5,
  output logic [SIZE-1:0] out_data6,
  output logic [SIZE-1:0] out_data7,
  output logic [NCH-1:0]  out_valid,
  input  logic [NCH-1:0]  out_ready,
  output logic [CNTW-1:0] accept_cnt
);
  logic [NCH-1:0]  vld;
  logic [NCH-1:0]  load;
  logic [SIZE-1:0] slot_data [NCH];
  logic            acc;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Only the addressed slot gates in_ready, so a stalled channel never
  // blocks words headed elsewhere.
  assign in_ready = ~vld[in_sel] | out_ready[in_sel];
  assign acc      = in_valid & in_ready;
  assign load     = acc ? sel_decode(in_sel) : '0;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    ydemux_slot #(.SIZE(SIZE)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .wdata (in_data),
      .rdy   (out_ready[k]),
      .rdata (slot_data[k]),
      .vld   (vld[k])
    );
  end

  assign cnt_d = acc ? cnt_q + CNTW'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_valid  = vld;
  assign accept_cnt = cnt_q;
  assign out_data0  = slot_data[0];
  assign out_data1  = slot_data[1];
  assign out_data2  = slot_data[2];
  assign out_data3  = slot_data[3];
  assign out_data4  = slot_data[4];
  assign out_data5  = slot_data[5];
  assign out_data6  = slot_data[6];
  assign out_data7  = slot_data[7];
endmodule

// File: tb/tb_ydemux1to8_buf.sv
// Bench for ydemux1to8_buf: directed cases plus a random sweep, all checked
// against per-channel word queues kept in the bench.
module tb_ydemux1to8_buf;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] od [8];
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [7:0]  accept_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq [8][$];
  logic [31:0] last [8];
  int          n_acc;
  bit          saw_wrap;
  bit          track_wrap;

  always #5 clk = ~clk;

  ydemux1to8_buf #(.SIZE(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data0  (od[0]),
    .out_data1  (od[1]),
    .out_data2  (od[2]),
    .out_data3  (od[3]),
    .out_data4  (od[4]),
    .out_data5  (od[5]),
    .out_data6  (od[6]),
    .out_data7  (od[7]),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .accept_cnt (accept_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      mq[k].delete();
      last[k] = 32'h0;
    end
    n_acc = 0;
  endtask

  task automatic check_state();
    logic [7:0] ev;
    ev = '0;
    for (int k = 0; k < 8; k++) begin
      ev[k] = (mq[k].size() != 0);
      chk($sformatf("out_data%0d", k), od[k], last[k]);
    end
    chk("out_valid", {24'h0, out_valid}, {24'h0, ev});
    chk("accept_cnt", {24'h0, accept_cnt}, n_acc % 256);
  endtask

  // One clock: drive at negedge, check in_ready and drained words, then check state after the edge.
  task automatic cycle(input logic v, input logic [2:0] s, input logic [31:0] d, input logic [7:0] r);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    exp_rdy = (mq[s].size() == 0) || r[s];
    chk("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    for (int k = 0; k < 8; k++) begin
      if (mq[k].size() != 0 && r[k]) begin
        chk($sformatf("drain_order%0d", k), od[k], mq[k][0]);
        void'(mq[k].pop_front());
      end
    end
    if (v && exp_rdy) begin
      mq[s].push_back(d);
      last[s] = d;
      n_acc++;
      if (track_wrap && n_acc % 256 == 0) saw_wrap = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    int acc0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    saw_wrap  = 1'b0;
    track_wrap = 1'b0;
    model_clear();
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset then idle
    cycle(1'b0, 3'd0, 32'h0, 8'h00);
    cycle(1'b0, 3'd4, 32'hFFFF_FFFF, 8'hFF);

    // single route to slot 5
    cycle(1'b1, 3'd5, 32'h0000_1234, 8'h00);
    chk("route5_valid", {24'h0, out_valid}, 32'h20);
    chk("route5_data", od[5], 32'h0000_1234);
    chk("route5_cnt", {24'h0, accept_cnt}, 32'h1);

    // backpressure isolation on slot 3
    cycle(1'b1, 3'd3, 32'hAAAA_3333, 8'h00);
    cycle(1'b1, 3'd3, 32'hDEAD_0003, 8'h00);
    chk("bp3_data", od[3], 32'hAAAA_3333);
    cycle(1'b1, 3'd6, 32'h6666_0006, 8'h00);
    chk("bp6_valid", {31'h0, out_valid[6]}, 32'h1);
    chk("bp3_stable", od[3], 32'hAAAA_3333);

    // simultaneous drain and refill on slot 0, then 10 back-to-back
    cycle(1'b1, 3'd0, 32'h0000_000A, 8'h00);
    cycle(1'b1, 3'd0, 32'h0000_000B, 8'h01);
    chk("refill0_valid", {31'h0, out_valid[0]}, 32'h1);
    chk("refill0_data", od[0], 32'h0000_000B);
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'd0, 32'h100 + i, 8'h01);
    chk("b2b_accepts", n_acc - acc0, 32'd10);

    // drain without refill on slot 7
    cycle(1'b1, 3'd7, 32'h7777_0007, 8'h00);
    cycle(1'b0, 3'd0, 32'h0, 8'h80);
    chk("drain7_valid", {31'h0, out_valid[7]}, 32'h0);
    chk("drain7_data", od[7], 32'h7777_0007);

    // asynchronous reset with slots 2 and 5 full
    cycle(1'b0, 3'd0, 32'h0, 8'hFF);
    cycle(1'b1, 3'd2, 32'h2222_0002, 8'h00);
    cycle(1'b1, 3'd5, 32'h5555_0005, 8'h00);
    chk("pre_rst_valid", {24'h0, out_valid}, 32'h24);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {24'h0, out_valid}, 32'h0);
    chk("async_rst_cnt", {24'h0, accept_cnt}, 32'h0);
    chk("async_rst_ready", {31'h0, in_ready}, 32'h1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 3'd2, 32'h0, 8'h00);

    // random sweep
    track_wrap = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(3, 0) != 0), 3'($urandom_range(7, 0)), $urandom, 8'($urandom));
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, 3'd0, 32'h0, 8'hFF);
    chk("rand_drained", {24'h0, out_valid}, 32'h0);
    chk("wrap_seen", {31'h0, saw_wrap}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
